interruptcontroller: RTL and testbench
======================================

# interruptcontroller

Memory-mapped interrupt source block that drives the `interrupts[7:0]` input of coprocessor 0. Synchronises seven asynchronous external request lines, latches edge- or level-type requests into a pending register, applies a software mask, and owns the system timer (count/compare) that raises line 7. Sits on the data-memory bus beside RAM; the exception handler services and clears requests through loads/stores.

## Interface
Parameters:
- `SYNC_STAGES`, 2, synchroniser depth for `irqsrc` (minimum 2)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- `irqsrc`  in  7  raw asynchronous external requests, active-high
- `sel`  in  1  chip select from address decoder
- `memwrite`  in  1  store strobe, effective only when `sel`=1
- `address`  in  3  word offset of register
- `writedata`  in  32  store data
- `readdata`  out  32  load data (combinational)
- `interrupts`  out  8  to CP0; bit 7 = timer, bits 6:0 = `irqsrc`

## Operation
- Register map (word offset): 0 PENDING (R, write-1-to-clear), 1 MASK (RW), 2 EDGE (RW, bit=1 edge-triggered, 0 level), 3 COUNT (RW), 4 COMPARE (RW), 5 TCTRL (bit0 enable, bit1 autoreload), 6–7 unmapped.
- Reset values: PENDING=0, MASK=0, EDGE=0, COUNT=0, COMPARE=0xFFFFFFFF, TCTRL=0, synchroniser flops 0; hence `interrupts`=0, `readdata`=0.
- `interrupts = PENDING[7:0] & MASK[7:0]`, combinational from registers.
- Source i (0..6), level mode: PENDING[i] follows synchronised level each cycle; W1C has no effect.
- Source i, edge mode: synchronised 0→1 transition sets PENDING[i]; W1C clears it; set and clear in same cycle → bit stays set.
- Switching EDGE[i] leaves PENDING[i] unchanged that cycle; new mode applies from next cycle.
- Timer: when TCTRL.enable, COUNT increments by 1 per cycle, wraps 0xFFFFFFFF→0. When enable and COUNT==COMPARE: PENDING[7] set (edge semantics, W1C clears, set wins); autoreload=1 → COUNT loads 0 next cycle, else keeps incrementing.
- Store to COUNT overrides increment/reload; match is evaluated on pre-write value.
- Store to COMPARE also clears PENDING[7] (MIPS-style ack), unless a match sets it that same cycle.
- Only bits 7:0 of MASK/EDGE/PENDING and 1:0 of TCTRL are stored; upper bits read 0, writes ignored.
- `readdata`: register at `address` when `sel`=1; 0 when `sel`=0 or address unmapped.

## Timing
- Stores take effect at the clock edge where `sel & memwrite`; readback reflects new value the following cycle.
- External edge: `irqsrc` high sampled at edge E → sync output at E+SYNC_STAGES−1 → PENDING/`interrupts` high after edge E+SYNC_STAGES (2 cycles default).
- Pulses shorter than one clock may be lost; no guarantee.
- Timer match at COUNT==COMPARE on edge E → PENDING[7] visible after E; with autoreload COUNT reads 0 after E.
- W1C at edge E → bit low after E (absent new set).
- `reset` mid-operation: all state returns to reset values at that edge; pending requests discarded.

## Structure
- Shared package `intc_pkg`: register offsets (PENDING..TCTRL), TCTRL bit positions, TIMER_LINE=7, COMPARE reset constant.
- Sub-module `intsync`: per-source SYNC_STAGES flop chain plus rising-edge detector (outputs `level`, `rise`), instantiated 7×.
- Timer kept inline in top module.

## Test plan
- Reset: assert `reset` 1 cycle → `interrupts`=0x00, reads of all regs = reset values (COMPARE=0xFFFFFFFF).
- Edge source: EDGE=0x01, MASK=0x01, pulse `irqsrc[0]` high 3 cycles → `interrupts`=0x01 two cycles after first sample, stays after drop; write PENDING=0x01 → 0x00 next cycle.
- Set/clear collision: edge on `irqsrc[3]` synced in same cycle as W1C of bit 3 → PENDING[3]=1.
- Level source with mask: EDGE=0, MASK=0 hold `irqsrc[5]`=1 → PENDING=0x20, `interrupts`=0; MASK=0x20 → `interrupts`=0x20; drop line → 0 after 2 cycles.
- Timer autoreload: COMPARE=4, TCTRL=3, MASK=0x80 → PENDING[7] set after 5th counting edge, COUNT reads 0, repeats every 5 cycles; write COMPARE → PENDING[7] cleared.
- Timer wrap: COUNT=0xFFFFFFFE, COMPARE=1, TCTRL=1 → COUNT 0xFFFFFFFF, 0, 1, match sets PENDING[7], COUNT continues to 2.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared constants for the interrupt controller: register offsets,
// timer control bit positions and reset values.
package intc_pkg;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_EDGE    = 3'd2;
  localparam logic [2:0] ADDR_COUNT   = 3'd3;
  localparam logic [2:0] ADDR_COMPARE = 3'd4;
  localparam logic [2:0] ADDR_TCTRL   = 3'd5;

  localparam int TCTRL_EN   = 0;
  localparam int TCTRL_AUTO = 1;

  localparam int NUM_EXT    = 7;
  localparam int TIMER_LINE = 7;

  localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/intsync.sv
// Per-source synchroniser: SYNC_STAGES flop chain followed by a registered
// copy of the synchronised level so a single-cycle rising-edge strobe can
// be produced.
module intsync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the raw request in at bit 0; the oldest sample is the level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], req_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and edge-history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/interruptcontroller.sv
// Memory-mapped interrupt source block: seven synchronised external lines
// plus a count/compare timer on line 7, a pending register with edge/level
// capture, and a software mask feeding CP0.
module interruptcontroller
  import intc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  irqsrc,
  input  logic        sel,
  input  logic        memwrite,
  input  logic [2:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  interrupts
);

  logic [7:0]  pending_q, pending_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  edge_q, edge_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [1:0]  tctrl_q, tctrl_d;

  logic [NUM_EXT-1:0] lvl, rise;

  logic       wr;
  logic       wr_pend, wr_mask, wr_edge, wr_count, wr_cmp, wr_tctrl;
  logic [7:0] w1c;
  logic       match;

  for (genvar g = 0; g < NUM_EXT; g++) begin : g_sync
    intsync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .req_i (irqsrc[g]),
      .level (lvl[g]),
      .rise  (rise[g])
    );
  end

  assign wr       = sel & memwrite;
  assign wr_pend  = wr && (address == ADDR_PENDING);
  assign wr_mask  = wr && (address == ADDR_MASK);
  assign wr_edge  = wr && (address == ADDR_EDGE);
  assign wr_count = wr && (address == ADDR_COUNT);
  assign wr_cmp   = wr && (address == ADDR_COMPARE);
  assign wr_tctrl = wr && (address == ADDR_TCTRL);
  assign w1c      = wr_pend ? writedata[7:0] : 8'h00;

  // Next-state for configuration, timer and pending bits.
  always_comb begin
    mask_d    = wr_mask  ? writedata[7:0] : mask_q;
    edge_d    = wr_edge  ? writedata[7:0] : edge_q;
    tctrl_d   = wr_tctrl ? writedata[1:0] : tctrl_q;
    compare_d = wr_cmp   ? writedata      : compare_q;

    // Match uses the pre-write COUNT/COMPARE values.
    match = tctrl_q[TCTRL_EN] && (count_q == compare_q);

    count_d = count_q;
    if (wr_count) begin
      count_d = writedata;
    end else if (tctrl_q[TCTRL_EN]) begin
      count_d = (match && tctrl_q[TCTRL_AUTO]) ? 32'd0 : count_q + 32'd1;
    end

    pending_d = pending_q;
    for (int i = 0; i < NUM_EXT; i++) begin
      if (wr_edge && (writedata[i] != edge_q[i])) begin
        // Mode change: hold this cycle, new mode applies next cycle.
        pending_d[i] = pending_q[i];
      end else if (edge_q[i]) begin
        pending_d[i] = rise[i] | (pending_q[i] & ~w1c[i]);
      end else begin
        pending_d[i] = lvl[i];
      end
    end
    // Timer line: match sets, W1C or a COMPARE store acknowledges.
    pending_d[TIMER_LINE] = match |
      (pending_q[TIMER_LINE] & ~(w1c[TIMER_LINE] | wr_cmp));
  end

  // Register bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 8'h00;
      mask_q    <= 8'h00;
      edge_q    <= 8'h00;
      count_q   <= 32'd0;
      compare_q <= COMPARE_RESET;
      tctrl_q   <= 2'b00;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      edge_q    <= edge_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      tctrl_q   <= tctrl_d;
    end
  end

  // Combinational load data; unmapped offsets and deselect read zero.
  always_comb begin
    readdata = 32'd0;
    if (sel) begin
      case (address)
        ADDR_PENDING: readdata = {24'd0, pending_q};
        ADDR_MASK:    readdata = {24'd0, mask_q};
        ADDR_EDGE:    readdata = {24'd0, edge_q};
        ADDR_COUNT:   readdata = count_q;
        ADDR_COMPARE: readdata = compare_q;
        ADDR_TCTRL:   readdata = {30'd0, tctrl_q};
        default:      readdata = 32'd0;
      endcase
    end
  end

  assign interrupts = pending_q & mask_q;

endmodule

// File: tb/tb_interruptcontroller.sv
// Self-checking bench for interruptcontroller: register-map vector table,
// hand-written timing sequences and randomized traffic against a
// behavioural model.
module tb_interruptcontroller;

  localparam int S = 2;

  logic        clk;
  logic        reset;
  logic [6:0]  irqsrc;
  logic        sel;
  logic        memwrite;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  interrupts;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] exp_q[$];

  interruptcontroller #(.SYNC_STAGES(S)) dut (
    .clk        (clk),
    .reset      (reset),
    .irqsrc     (irqsrc),
    .sel        (sel),
    .memwrite   (memwrite),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .interrupts (interrupts)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural reference model ----------------
  // Synchroniser modelled as a history of raw samples: the level seen at an
  // edge is the sample taken S edges earlier, the previous level S+1 back.
  logic [7:0]  m_pend, m_mask, m_edge;
  logic [31:0] m_count, m_cmp;
  logic [1:0]  m_tctrl;
  logic [6:0]  m_hist[$];
  logic [6:0]  m_lvl, m_prv;
  logic [7:0]  n_pend;
  logic        m_wr, m_match;

  always @(posedge clk) begin
    if (reset) begin
      m_pend = 8'h00; m_mask = 8'h00; m_edge = 8'h00;
      m_count = 32'd0; m_cmp = 32'hFFFF_FFFF; m_tctrl = 2'b00;
      m_hist.delete();
      for (int k = 0; k <= S; k++) m_hist.push_back(7'h00);
    end else begin
      m_lvl   = m_hist[1];
      m_prv   = m_hist[0];
      m_wr    = sel && memwrite;
      m_match = m_tctrl[0] && (m_count == m_cmp);
      n_pend  = m_pend;
      for (int i = 0; i < 7; i++) begin
        if (m_wr && address == 3'd2 && writedata[i] != m_edge[i])
          n_pend[i] = m_pend[i];
        else if (m_edge[i]) begin
          if (m_lvl[i] && !m_prv[i]) n_pend[i] = 1'b1;
          else if (m_wr && address == 3'd0 && writedata[i]) n_pend[i] = 1'b0;
        end else
          n_pend[i] = m_lvl[i];
      end
      if (m_match) n_pend[7] = 1'b1;
      else if (m_wr && ((address == 3'd0 && writedata[7]) || address == 3'd4))
        n_pend[7] = 1'b0;
      if (m_wr && address == 3'd3) m_count = writedata;
      else if (m_tctrl[0]) m_count = (m_match && m_tctrl[1]) ? 32'd0 : m_count + 1;
      if (m_wr && address == 3'd1) m_mask  = writedata[7:0];
      if (m_wr && address == 3'd2) m_edge  = writedata[7:0];
      if (m_wr && address == 3'd4) m_cmp   = writedata;
      if (m_wr && address == 3'd5) m_tctrl = writedata[1:0];
      m_pend = n_pend;
      m_hist.push_back(irqsrc);
      void'(m_hist.pop_front());
    end
  end

  function automatic logic [31:0] m_rd();
    if (!sel) return 32'd0;
    case (address)
      3'd0: return {24'd0, m_pend};
      3'd1: return {24'd0, m_mask};
      3'd2: return {24'd0, m_edge};
      3'd3: return m_count;
      3'd4: return m_cmp;
      3'd5: return {30'd0, m_tctrl};
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- scoreboard / driver tasks ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_checks();
    check("irq_vs_model", {24'd0, interrupts}, {24'd0, m_pend & m_mask});
    check("rd_vs_model", readdata, m_rd());
  endtask

  task automatic idle();
    sel = 1'b0; memwrite = 1'b0; address = 3'd0; writedata = 32'd0;
  endtask

  // One clock: settle, compare against the model, advance to next negedge.
  task automatic step();
    #1;
    model_checks();
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    sel = 1'b1; memwrite = 1'b1; address = a; writedata = d;
    step();
    idle();
  endtask

  task automatic rd_check(input string nm, input logic [2:0] a, input logic [31:0] exp);
    sel = 1'b1; memwrite = 1'b0; address = a; writedata = 32'd0;
    #1;
    check(nm, readdata, exp);
    model_checks();
    @(negedge clk);
    idle();
  endtask

  task automatic irq_check(input string nm, input logic [7:0] exp);
    #1;
    check(nm, {24'd0, interrupts}, {24'd0, exp});
    model_checks();
    @(negedge clk);
  endtask

  task automatic irq_now(input string nm, input logic [7:0] exp);
    #1;
    check(nm, {24'd0, interrupts}, {24'd0, exp});
  endtask

  typedef struct {
    logic        we;
    logic        sel;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    reset = 1'b1;
    irqsrc = 7'h00;
    idle();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // ---- reset state and register map (table-driven) ----
    irq_check("reset_int", 8'h00);
    tbl.push_back('{1'b0, 1'b1, 3'd0, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 1'b1, 3'd1, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 1'b1, 3'd2, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 1'b1, 3'd3, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 1'b1, 3'd4, 32'h0, 32'hFFFF_FFFF});
    tbl.push_back('{1'b0, 1'b1, 3'd5, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'd1, 32'h0, 32'h0000_00FF});
    tbl.push_back('{1'b1, 1'b1, 3'd2, 32'hA5A5_A5AA, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'd2, 32'h0, 32'h0000_00AA});
    tbl.push_back('{1'b1, 1'b1, 3'd4, 32'h1234_5678, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'd4, 32'h0, 32'h1234_5678});
    tbl.push_back('{1'b1, 1'b1, 3'd3, 32'hCAFE_F00D, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'd3, 32'h0, 32'hCAFE_F00D});
    tbl.push_back('{1'b0, 1'b1, 3'd6, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 1'b1, 3'd7, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 1'b0, 3'd4, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 3'd1, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'd1, 32'h0, 32'h0000_00FF});
    tbl.push_back('{1'b1, 1'b1, 3'd5, 32'hFFFF_FFFC, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'd5, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 1'b1, 3'd0, 32'h0, 32'h0000_0000});

    for (int v = 0; v < tbl.size(); v++) begin
      sel = tbl[v].sel; address = tbl[v].addr; writedata = tbl[v].wd;
      memwrite = tbl[v].we;
      if (tbl[v].we) begin
        step();
      end else begin
        exp_q.push_back(tbl[v].exp);
        #1;
        check($sformatf("regmap_%0d", v), readdata, exp_q.pop_front());
        model_checks();
        @(negedge clk);
      end
      idle();
    end

    // ---- edge source on line 0 ----
    wr_reg(3'd1, 32'h01);
    wr_reg(3'd2, 32'h01);
    irqsrc = 7'h01;
    irq_check("edge_pre0", 8'h00);
    irq_check("edge_pre1", 8'h00);
    irq_check("edge_pre2", 8'h00);
    irqsrc = 7'h00;
    irq_check("edge_set", 8'h01);
    irq_check("edge_hold1", 8'h01);
    irq_check("edge_hold2", 8'h01);
    wr_reg(3'd0, 32'h01);
    irq_check("edge_w1c", 8'h00);

    // ---- set/clear collision on line 3 ----
    wr_reg(3'd2, 32'h08);
    wr_reg(3'd1, 32'h08);
    irqsrc = 7'h08;
    step();
    step();
    wr_reg(3'd0, 32'h08);
    irq_now("collide_int", 8'h08);
    rd_check("collide_pend", 3'd0, 32'h08);
    wr_reg(3'd0, 32'h08);
    irq_check("collide_clr", 8'h00);
    irqsrc = 7'h00;
    step(); step(); step();

    // ---- level source on line 5 with mask ----
    wr_reg(3'd2, 32'h00);
    wr_reg(3'd1, 32'h00);
    irqsrc = 7'h20;
    step(); step(); step(); step();
    rd_check("level_pend", 3'd0, 32'h20);
    irq_check("level_masked", 8'h00);
    wr_reg(3'd1, 32'h20);
    irq_check("level_unmasked", 8'h20);
    wr_reg(3'd0, 32'h20);
    irq_check("level_w1c_noeff", 8'h20);
    irqsrc = 7'h00;
    irq_check("level_drop0", 8'h20);
    irq_check("level_drop1", 8'h20);
    irq_check("level_drop2", 8'h20);
    irq_check("level_low", 8'h00);

    // ---- timer autoreload ----
    wr_reg(3'd1, 32'h80);
    wr_reg(3'd4, 32'd4);
    wr_reg(3'd3, 32'd0);
    wr_reg(3'd5, 32'd3);
    for (int k = 0; k < 5; k++) begin
      irq_now("tmr_nomatch", 8'h00);
      rd_check("tmr_count", 3'd3, k);
    end
    irq_now("tmr_match", 8'h80);
    rd_check("tmr_reload", 3'd3, 32'd0);
    wr_reg(3'd0, 32'h80);
    irq_now("tmr_w1c", 8'h00);
    rd_check("tmr_cnt2", 3'd3, 32'd2);
    rd_check("tmr_cnt3", 3'd3, 32'd3);
    irq_now("tmr_before_rep", 8'h00);
    rd_check("tmr_cnt4", 3'd3, 32'd4);
    irq_now("tmr_repeat", 8'h80);
    rd_check("tmr_reload2", 3'd3, 32'd0);
    wr_reg(3'd4, 32'd100);
    irq_now("tmr_cmp_ack", 8'h00);
    wr_reg(3'd5, 32'd0);

    // ---- timer wrap ----
    wr_reg(3'd3, 32'hFFFF_FFFE);
    wr_reg(3'd4, 32'd1);
    wr_reg(3'd5, 32'd1);
    rd_check("wrap_fe", 3'd3, 32'hFFFF_FFFE);
    rd_check("wrap_ff", 3'd3, 32'hFFFF_FFFF);
    rd_check("wrap_0", 3'd3, 32'd0);
    irq_now("wrap_nomatch", 8'h00);
    rd_check("wrap_1", 3'd3, 32'd1);
    irq_now("wrap_match", 8'h80);
    rd_check("wrap_2", 3'd3, 32'd2);

    // ---- reset mid-operation ----
    reset = 1'b1;
    step();
    reset = 1'b0;
    irq_now("rst_int", 8'h00);
    rd_check("rst_mask", 3'd1, 32'd0);
    rd_check("rst_compare", 3'd4, 32'hFFFF_FFFF);
    rd_check("rst_count", 3'd3, 32'd0);
    rd_check("rst_tctrl", 3'd5, 32'd0);

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) irqsrc = 7'($urandom);
      sel      = 1'($urandom_range(0, 1));
      memwrite = 1'($urandom_range(0, 1));
      address  = 3'($urandom_range(0, 7));
      if (address == 3'd3 || address == 3'd4)
        writedata = $urandom_range(0, 24);
      else
        writedata = $urandom;
      reset = ($urandom_range(0, 400) == 0);
      step();
    end
    reset = 1'b0;
    idle();
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
